// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the I/D main-memory arbiter.
// Optional round-robin tie-break is enabled with the MEM_ARB_RR_EN macro.
package mem_arbiter_pkg;

   localparam int unsigned GNT_W = 2;
   localparam int unsigned GNT_I = 0;
   localparam int unsigned GNT_D = 1;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_GRANT_I = 2'd1,
      ARB_GRANT_D = 2'd2,
      ARB_RELEASE = 2'd3
   } arb_state_e;

   // Identity of the requester that owned the last completed transfer
   typedef enum logic {
      OWNER_I = 1'b0,
      OWNER_D = 1'b1
   } owner_e;

   function automatic logic is_grant_state(input arb_state_e st);
      return (st == ARB_GRANT_I) || (st == ARB_GRANT_D);
   endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational 2-way request picker returning a one-hot winner.
// MEM_ARB_RR_EN selects round-robin tie-break; otherwise D-side has fixed priority.
module arb_pick
   import mem_arbiter_pkg::*;
(
   input  logic             i_valid,
   input  logic             d_valid,
   input  logic             last_owner,
   output logic [GNT_W-1:0] pick
);

`ifdef MEM_ARB_RR_EN
   // On a tie, favour whoever did not own the last completed transfer
   always_comb begin
      pick = '0;
      if (i_valid && d_valid) begin
         if (last_owner == 1'(OWNER_D)) begin
            pick[GNT_I] = 1'b1;
         end else begin
            pick[GNT_D] = 1'b1;
         end
      end else if (d_valid) begin
         pick[GNT_D] = 1'b1;
      end else if (i_valid) begin
         pick[GNT_I] = 1'b1;
      end
   end
`else
   logic unused_last_owner;
   assign unused_last_owner = last_owner;

   always_comb begin
      pick = '0;
      if (d_valid) begin
         pick[GNT_D] = 1'b1;
      end else if (i_valid) begin
         pick[GNT_I] = 1'b1;
      end
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single main-memory port between I-cache and D-cache engines.
// Define MEM_ARB_RR_EN for round-robin tie-break; default is fixed D-side priority.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic              i_req_valid,
   input  logic              i_req_wr,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              i_req_ready,
   output logic [DATA_W-1:0] i_req_data,
   input  logic [ADDR_W-1:0] d_req_addr,
   input  logic              d_req_valid,
   input  logic              d_req_wr,
   input  logic [DATA_W-1:0] d_wr_data,
   output logic              d_req_ready,
   output logic [DATA_W-1:0] d_req_data,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   output logic              mem_req_valid,
   output logic              mem_req_wr,
   input  logic              mem_req_ready,
   input  logic [DATA_W-1:0] mem_req_data,
   output logic [1:0]        grant
);

   arb_state_e        state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              valid_q;
   logic              wr_q;
   logic [GNT_W-1:0]  grant_q;
   logic [GNT_W-1:0]  pick;
   logic              last_owner;
   logic              xfer_done;

   assign xfer_done = is_grant_state(state_q) && mem_req_ready;

`ifdef MEM_ARB_RR_EN
   logic last_owner_q;

   // Remembers who completed the most recent transfer for the tie-break
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_owner_q <= 1'(OWNER_I);
      end else if (xfer_done) begin
         last_owner_q <= (state_q == ARB_GRANT_D);
      end
   end

   assign last_owner = last_owner_q;
`else
   assign last_owner = 1'(OWNER_I);
`endif

   arb_pick u_pick (
      .i_valid    (i_req_valid),
      .d_valid    (d_req_valid),
      .last_owner (last_owner),
      .pick       (pick)
   );

   // Arbitration FSM; memory-side outputs are held stable while granted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         valid_q <= 1'b0;
         wr_q    <= 1'b0;
         grant_q <= '0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (pick[GNT_D]) begin
                  addr_q         <= d_req_addr;
                  wdata_q        <= d_wr_data;
                  wr_q           <= d_req_wr;
                  valid_q        <= 1'b1;
                  grant_q        <= '0;
                  grant_q[GNT_D] <= 1'b1;
                  state_q        <= ARB_GRANT_D;
               end else if (pick[GNT_I]) begin
                  addr_q         <= i_req_addr;
                  wdata_q        <= i_wr_data;
                  wr_q           <= i_req_wr;
                  valid_q        <= 1'b1;
                  grant_q        <= '0;
                  grant_q[GNT_I] <= 1'b1;
                  state_q        <= ARB_GRANT_I;
               end
            end
            ARB_GRANT_I, ARB_GRANT_D: begin
               if (mem_req_ready) begin
                  valid_q <= 1'b0;
                  wr_q    <= 1'b0;
                  grant_q <= '0;
                  state_q <= ARB_RELEASE;
               end
            end
            ARB_RELEASE: begin
               state_q <= ARB_IDLE;
            end
            default: begin
               state_q <= ARB_IDLE;
            end
         endcase
      end
   end

   assign mem_req_addr  = addr_q;
   assign mem_wr_data   = wdata_q;
   assign mem_req_valid = valid_q;
   assign mem_req_wr    = wr_q;
   assign grant         = grant_q;

   // Response routing: only the owner sees ready/data, and only while it still requests
   assign i_req_ready = grant_q[GNT_I] && mem_req_ready && i_req_valid;
   assign d_req_ready = grant_q[GNT_D] && mem_req_ready && d_req_valid;
   assign i_req_data  = grant_q[GNT_I] ? mem_req_data : '0;
   assign d_req_data  = grant_q[GNT_D] ? mem_req_data : '0;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between the instruction cache (I-side) and data cache (D-side) refill/write-back engines.
- Each cache drives a valid/ready request interface identical to the cache-to-memory interface. The arbiter grants one requester at a time, forwards its request to memory and routes the response back.
- Sits between both caches and the memory model/controller. It is the only master on the memory port.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- i_req_addr  in  ADDR_W  I-side address
- i_req_valid  in  1  I-side request
- i_req_wr  in  1  I-side write (0 = read)
- i_wr_data  in  DATA_W  I-side write data
- i_req_ready  out  1  I-side transfer complete
- i_req_data  out  DATA_W  I-side read data
- d_req_addr  in  ADDR_W  D-side address
- d_req_valid  in  1  D-side request
- d_req_wr  in  1  D-side write
- d_wr_data  in  DATA_W  D-side write data
- d_req_ready  out  1  D-side transfer complete
- d_req_data  out  DATA_W  D-side read data
- mem_req_addr  out  ADDR_W  memory address (registered)
- mem_wr_data  out  DATA_W  memory write data (registered)
- mem_req_valid  out  1  memory request (registered)
- mem_req_wr  out  1  memory write (registered)
- mem_req_ready  in  1  memory done, read data valid
- mem_req_data  in  DATA_W  memory read data
- grant  out  2  one-hot current owner: bit0 = I, bit1 = D

Behaviour:
- Reset:
  - Asynchronous; takes effect immediately, mid-transaction included.
  - State = ARB_IDLE; mem_req_valid, mem_req_wr, grant, i/d_req_ready = 0; mem_req_addr, mem_wr_data = 0.
  - An abandoned memory transaction is dropped; memory must tolerate valid falling without ready.
- States:
  - ARB_IDLE: no owner. Sample i/d valid. Winner selected per the priority rule:
    - Register the winner's addr/wr/wdata onto the mem_* outputs.
    - Set mem_req_valid = 1 and the grant bit.
    - Go to ARB_GRANT_I or ARB_GRANT_D. Latency: request visible to memory 1 cycle after valid is sampled high in ARB_IDLE.
  - ARB_GRANT_x: hold mem_* outputs stable.
    - x_req_ready = mem_req_ready (combinational); x_req_data = mem_req_data.
    - Other requester: ready = 0, data = 0.
    - On mem_req_ready = 1: drop mem_req_valid and grant next edge; go to ARB_RELEASE and record the last owner.
  - ARB_RELEASE: one dead cycle with no grant, so the requester can deassert valid. Then go to ARB_IDLE.
- Priority (default, macro absent): fixed. D-side wins on simultaneous valid.
- Non-granted requester keeps valid asserted; it is never dropped or reordered.
- Ready is never asserted to a requester whose valid is low.
- mem_req_ready while in ARB_IDLE/ARB_RELEASE is ignored.
- Minimum turnaround per transfer: 1 (issue) + N memory cycles + 1 (release). Back-to-back requests from the same requester are allowed after ARB_RELEASE.
- Valid deasserted by the owner mid-grant: illegal, not checked. The arbiter keeps the transaction until mem_req_ready.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin. On a simultaneous request in ARB_IDLE, grant the requester that did NOT own the last completed transfer. The last-owner flop resets to I, so D wins the first tie.
- Absent: fixed D-priority as above; last-owner flop not instantiated.

Decomposition:
- Shared package/header:
  - State encoding localparams: ARB_IDLE = 2'd0, ARB_GRANT_I = 2'd1, ARB_GRANT_D = 2'd2, ARB_RELEASE = 2'd3.
  - Grant bit indices GNT_I = 0, GNT_D = 1.
- One sub-module: arb_pick. Combinational 2-way picker taking (i_valid, d_valid, last_owner) and returning a one-hot pick. It contains the MEM_ARB_RR_EN selection, so the FSM is policy-agnostic.

Test Plan:
- Single I read: i_req_valid = 1, addr 0x100, memory 3-cycle latency returns 0xDEADBEEF.
  - mem_req_valid rises 1 cycle after the request; addr = 0x100, wr = 0.
  - i_req_ready pulses 1 cycle with i_req_data = 0xDEADBEEF; grant = 01 during the transfer.
- Simultaneous I and D requests (D write 0x200, data 0x5A5A5A5A):
  - Default: D is served first (mem_req_wr = 1, wdata = 0x5A5A5A5A); I is served after ARB_RELEASE.
  - With MEM_ARB_RR_EN: the second tie goes to I.
- Continuous D requests with I pending, MEM_ARB_RR_EN defined: grants alternate D, I, D, I; no starvation over 8 transfers.
- Late arrival: D request arrives while I is mid-transfer.
  - mem_req_addr stays at the I address until mem_req_ready.
  - d_req_ready stays 0 and D is granted next.
- Reset asserted asynchronously mid-grant (no clock edge): mem_req_valid, grant and both ready outputs go 0 immediately. After release, state = ARB_IDLE and the pending request is reissued.
- Stray mem_req_ready = 1 in ARB_IDLE: no ready pulse on either side, no state change.
